// File: rtl/fdma_pkg.sv
// rtl/fdma_pkg.sv - shared state types and derived-constant helpers for the FDMA write scheduler
package fdma_pkg;

  typedef enum logic [1:0] {C_IDLE, C_RST, C_ARMED, C_LAST} ch_state_t;
  typedef enum logic [1:0] {A_ARB, A_REQ, A_BUSY, A_DONE} arb_state_t;

  function automatic int burst_f(input int xsize, input int dw, input int axi_dw, input int xdiv);
    return xsize * dw / axi_dw / xdiv;
  endfunction

  function automatic int inc_f(input int xsize, input int dw, input int xdiv);
    return xsize * dw / 8 / xdiv;
  endfunction

  // Last burst of a line also skips the stride padding.
  function automatic int last_inc_f(input int xsize, input int xstride, input int dw, input int xdiv);
    return (xstride - xsize) * dw / 8 + inc_f(xsize, dw, xdiv);
  endfunction

  function automatic int nburst_f(input int ysize, input int xdiv);
    return ysize * xdiv;
  endfunction

  function automatic int clog2_f(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fdma_wr_sched_if.sv
// rtl/fdma_wr_sched_if.sv - FDMA write port bundle between scheduler and AXI master
interface fdma_wr_sched_if #(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0] O_fdma_waddr;
  logic                      O_fdma_wareq;
  logic [15:0]               O_fdma_wsize;
  logic [AXI_DATA_WIDTH-1:0] O_fdma_wdata;
  logic                      I_fdma_wbusy;
  logic                      I_fdma_wvalid;

  modport master (
    output O_fdma_waddr, O_fdma_wareq, O_fdma_wsize, O_fdma_wdata,
    input  I_fdma_wbusy, I_fdma_wvalid
  );

  modport slave (
    input  O_fdma_waddr, O_fdma_wareq, O_fdma_wsize, O_fdma_wdata,
    output I_fdma_wbusy, I_fdma_wvalid
  );
endinterface

// File: rtl/fdma_wr_ch_ctrl.sv
// rtl/fdma_wr_ch_ctrl.sv - per-channel frame sync, FIFO reset, burst addressing and IRQ
module fdma_wr_ch_ctrl
  import fdma_pkg::*;
#(
  parameter int CNT_WIDTH      = 12,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int W_DATAWIDTH    = 32,
  parameter int W_DSIZEBITS    = 24,
  parameter int W_XSIZE        = 1920,
  parameter int W_XSTRIDE      = 1920,
  parameter int W_YSIZE        = 1080,
  parameter int W_XDIV         = 2,
  parameter int W_BUFSIZE      = 3,
  parameter int RST_CYCLES     = 40,
  parameter int RST_GUARD      = 60,
  parameter int IRQ_CYCLES     = 60,
  parameter int VIDEO_ENABLE   = 1
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   fs,
  input  logic [CNT_WIDTH-1:0]   rcnt,
  input  logic [7:0]             buf_in,
  input  logic                   arb_sync,
  input  logic                   pick,
  input  logic                   done,
  output logic                   eligible,
  output logic                   fifo_rst,
  output logic [7:0]             sync_cnt,
  output logic [7:0]             bufn,
  output logic [7:0]             wbuf,
  output logic [W_DSIZEBITS-1:0] offset,
  output logic                   irq,
  output logic                   ovf
);

  localparam int BURST    = burst_f(W_XSIZE, W_DATAWIDTH, AXI_DATA_WIDTH, W_XDIV);
  localparam int INC      = inc_f(W_XSIZE, W_DATAWIDTH, W_XDIV);
  localparam int LAST_INC = last_inc_f(W_XSIZE, W_XSTRIDE, W_DATAWIDTH, W_XDIV);
  localparam int NBURST   = nburst_f(W_YSIZE, W_XDIV);
  localparam int RCW      = clog2_f(RST_CYCLES + RST_GUARD + 1);
  localparam int ICW      = clog2_f(IRQ_CYCLES + 1);
  localparam int BW       = clog2_f(NBURST + 1);
  localparam int DVW      = clog2_f(W_XDIV + 1);
  localparam logic [RCW-1:0] RST_END = RCW'(RST_CYCLES + RST_GUARD - 1);

  ch_state_t              state_q, state_d;
  logic [RCW-1:0]         rst_cnt_q, rst_cnt_d;
  logic                   fifo_rst_q, fifo_rst_d;
  logic [7:0]             sync_q, sync_d;
  logic [7:0]             bufn_q, bufn_d;
  logic [7:0]             wbuf_q, wbuf_d;
  logic [W_DSIZEBITS-1:0] offset_q, offset_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [DVW-1:0]         div_q, div_d;
  logic [ICW-1:0]         irq_cnt_q, irq_cnt_d;
  logic                   irq_q, irq_d;
  logic                   ovf_q, ovf_d;
  logic                   fs_eff, last_burst;

  assign fs_eff     = (VIDEO_ENABLE != 0) ? fs : 1'b1;
  assign last_burst = (bcnt_q == BW'(NBURST - 1));

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    fifo_rst_d = fifo_rst_q;
    sync_d     = sync_q;
    bufn_d     = bufn_q;
    wbuf_d     = wbuf_q;
    offset_d   = offset_q;
    bcnt_d     = bcnt_q;
    div_d      = div_q;
    irq_cnt_d  = irq_cnt_q;
    ovf_d      = ovf_q;

    if (irq_cnt_q != '0) irq_cnt_d = irq_cnt_q - 1'b1;
    if ((VIDEO_ENABLE != 0) && fs && (state_q != C_IDLE)) ovf_d = 1'b1;

    case (state_q)
      C_IDLE: begin
        offset_d  = '0;
        bcnt_d    = '0;
        div_d     = '0;
        rst_cnt_d = '0;
        if (fs_eff && en) begin
          state_d    = C_RST;
          sync_d     = (sync_q == 8'(W_BUFSIZE - 1)) ? 8'd0 : sync_q + 8'd1;
          fifo_rst_d = (VIDEO_ENABLE != 0) && (RST_CYCLES > 0);
        end
      end
      C_RST: begin
        if (rst_cnt_q == '0) bufn_d = buf_in;
        if (rst_cnt_q != RST_END) rst_cnt_d = rst_cnt_q + 1'b1;
        fifo_rst_d = (int'(rst_cnt_q) + 1 < RST_CYCLES);
        if (VIDEO_ENABLE == 0) begin
          fifo_rst_d = 1'b0;
          state_d    = C_ARMED;
        end else if ((rst_cnt_q == RST_END) && !irq_q) begin
          state_d = C_ARMED;
        end
      end
      C_ARMED: begin
        if (pick) begin
          if (last_burst) state_d = C_LAST;
        end else if (arb_sync && !en) begin
          state_d = C_IDLE;
        end
      end
      default: ;
    endcase

    if (done) begin
      if (div_q == DVW'(W_XDIV - 1)) begin
        offset_d = offset_q + W_DSIZEBITS'(LAST_INC);
        div_d    = '0;
      end else begin
        offset_d = offset_q + W_DSIZEBITS'(INC);
        div_d    = div_q + 1'b1;
      end
      bcnt_d = bcnt_q + 1'b1;
      if (last_burst) begin
        state_d   = C_IDLE;
        wbuf_d    = bufn_q;
        irq_cnt_d = ICW'(IRQ_CYCLES);
      end
    end

    irq_d = (irq_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= C_IDLE;
      rst_cnt_q  <= '0;
      fifo_rst_q <= 1'b0;
      sync_q     <= '0;
      bufn_q     <= '0;
      wbuf_q     <= '0;
      offset_q   <= '0;
      bcnt_q     <= '0;
      div_q      <= '0;
      irq_cnt_q  <= '0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      fifo_rst_q <= fifo_rst_d;
      sync_q     <= sync_d;
      bufn_q     <= bufn_d;
      wbuf_q     <= wbuf_d;
      offset_q   <= offset_d;
      bcnt_q     <= bcnt_d;
      div_q      <= div_d;
      irq_cnt_q  <= irq_cnt_d;
      irq_q      <= irq_d;
      ovf_q      <= ovf_d;
    end
  end

  assign eligible = (state_q == C_ARMED) && (rcnt >= CNT_WIDTH'(BURST));
  assign fifo_rst = fifo_rst_q;
  assign sync_cnt = sync_q;
  assign bufn     = bufn_q;
  assign wbuf     = wbuf_q;
  assign offset   = offset_q;
  assign irq      = irq_q;
  assign ovf      = ovf_q;

endmodule

// File: rtl/fdma_wr_sched.sv
// rtl/fdma_wr_sched.sv - round-robin arbiter of CH_NUM video write channels onto one FDMA write port
module fdma_wr_sched
  import fdma_pkg::*;
#(
  parameter int          CH_NUM         = 4,
  parameter int          AXI_DATA_WIDTH = 128,
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          CNT_WIDTH      = 12,
  parameter int          W_DATAWIDTH    = 32,
  parameter int unsigned W_BASEADDR     = 0,
  parameter int          W_DSIZEBITS    = 24,
  parameter int          CH_ADDR_SHIFT  = 27,
  parameter int          W_XSIZE        = 1920,
  parameter int          W_XSTRIDE      = 1920,
  parameter int          W_YSIZE        = 1080,
  parameter int          W_XDIV         = 2,
  parameter int          W_BUFSIZE      = 3,
  parameter int          RST_CYCLES     = 40,
  parameter int          RST_GUARD      = 60,
  parameter int          IRQ_CYCLES     = 60,
  parameter int          VIDEO_ENABLE   = 1
)(
  input  logic                             I_ui_clk,
  input  logic                             I_ui_rst,
  input  logic [CH_NUM-1:0]                I_ch_en,
  input  logic [CH_NUM-1:0]                I_W_FS,
  input  logic [CH_NUM*CNT_WIDTH-1:0]      I_W_rcnt,
  input  logic [CH_NUM*8-1:0]              I_W_buf,
  input  logic [CH_NUM*AXI_DATA_WIDTH-1:0] I_W_fifo_dout,
  output logic [CH_NUM-1:0]                O_fifo_re,
  output logic [CH_NUM-1:0]                O_fifo_rst,
  output logic [CH_NUM*8-1:0]              O_W_sync_cnt,
  fdma_wr_sched_if.master                  fdma,
  output logic [CH_NUM*8-1:0]              O_fdma_wbuf,
  output logic [CH_NUM-1:0]                O_fdma_wirq,
  output logic [CH_NUM-1:0]                O_fs_ovf
);

  localparam int GW    = clog2_f(CH_NUM);
  localparam int BURST = burst_f(W_XSIZE, W_DATAWIDTH, AXI_DATA_WIDTH, W_XDIV);

  arb_state_t                arb_q, arb_d;
  logic [GW-1:0]             grant_q, grant_d;
  logic [GW-1:0]             ptr_q, ptr_d;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                      wareq_q, wareq_d;
  logic [15:0]               wsize_q, wsize_d;

  logic [CH_NUM-1:0]         eligible, pick_v, done_v;
  logic [7:0]                ch_bufn   [CH_NUM];
  logic [W_DSIZEBITS-1:0]    ch_offset [CH_NUM];
  logic                      arb_sync, found;
  logic [GW-1:0]             sel;

  assign arb_sync = (arb_q == A_ARB);

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    fdma_wr_ch_ctrl #(
      .CNT_WIDTH      (CNT_WIDTH),
      .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
      .W_DATAWIDTH    (W_DATAWIDTH),
      .W_DSIZEBITS    (W_DSIZEBITS),
      .W_XSIZE        (W_XSIZE),
      .W_XSTRIDE      (W_XSTRIDE),
      .W_YSIZE        (W_YSIZE),
      .W_XDIV         (W_XDIV),
      .W_BUFSIZE      (W_BUFSIZE),
      .RST_CYCLES     (RST_CYCLES),
      .RST_GUARD      (RST_GUARD),
      .IRQ_CYCLES     (IRQ_CYCLES),
      .VIDEO_ENABLE   (VIDEO_ENABLE)
    ) u_ch (
      .clk      (I_ui_clk),
      .rst      (I_ui_rst),
      .en       (I_ch_en[g]),
      .fs       (I_W_FS[g]),
      .rcnt     (I_W_rcnt[g*CNT_WIDTH +: CNT_WIDTH]),
      .buf_in   (I_W_buf[g*8 +: 8]),
      .arb_sync (arb_sync),
      .pick     (pick_v[g]),
      .done     (done_v[g]),
      .eligible (eligible[g]),
      .fifo_rst (O_fifo_rst[g]),
      .sync_cnt (O_W_sync_cnt[g*8 +: 8]),
      .bufn     (ch_bufn[g]),
      .wbuf     (O_fdma_wbuf[g*8 +: 8]),
      .offset   (ch_offset[g]),
      .irq      (O_fdma_wirq[g]),
      .ovf      (O_fs_ovf[g])
    );
  end

  always_comb begin
    arb_d   = arb_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    waddr_d = waddr_q;
    wareq_d = wareq_q;
    wsize_d = 16'(BURST);
    pick_v  = '0;
    done_v  = '0;
    found   = 1'b0;
    sel     = '0;

    case (arb_q)
      A_ARB: begin
        wareq_d = 1'b0;
        // First eligible channel at or after the pointer wins.
        for (int k = 0; k < CH_NUM; k++) begin
          if (!found && eligible[(int'(ptr_q) + k) % CH_NUM]) begin
            found = 1'b1;
            sel   = GW'((int'(ptr_q) + k) % CH_NUM);
          end
        end
        if (found) begin
          pick_v[sel] = 1'b1;
          grant_d     = sel;
          waddr_d     = AXI_ADDR_WIDTH'(W_BASEADDR)
                      + (AXI_ADDR_WIDTH'(sel) << CH_ADDR_SHIFT)
                      + AXI_ADDR_WIDTH'({ch_bufn[sel], ch_offset[sel]});
          wareq_d     = 1'b1;
          arb_d       = A_REQ;
        end
      end
      A_REQ: begin
        if (fdma.I_fdma_wbusy) begin
          wareq_d = 1'b0;
          arb_d   = A_BUSY;
        end else begin
          wareq_d = 1'b1;
        end
      end
      A_BUSY: begin
        if (!fdma.I_fdma_wbusy) arb_d = A_DONE;
      end
      A_DONE: begin
        done_v[grant_q] = 1'b1;
        ptr_d = (int'(grant_q) == CH_NUM - 1) ? '0 : grant_q + 1'b1;
        arb_d = A_ARB;
      end
      default: arb_d = A_ARB;
    endcase
  end

  always_ff @(posedge I_ui_clk) begin
    if (I_ui_rst) begin
      arb_q   <= A_ARB;
      grant_q <= '0;
      ptr_q   <= '0;
      waddr_q <= '0;
      wareq_q <= 1'b0;
      wsize_q <= '0;
    end else begin
      arb_q   <= arb_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      waddr_q <= waddr_d;
      wareq_q <= wareq_d;
      wsize_q <= wsize_d;
    end
  end

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      O_fifo_re[c] = fdma.I_fdma_wvalid && (grant_q == GW'(c))
                   && ((arb_q == A_REQ) || (arb_q == A_BUSY));
    end
  end

  assign fdma.O_fdma_wdata = I_W_fifo_dout[int'(grant_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign fdma.O_fdma_waddr = waddr_q;
  assign fdma.O_fdma_wareq = wareq_q;
  assign fdma.O_fdma_wsize = wsize_q;

endmodule

// File: tb/tb_fdma_wr_sched.sv
// tb/tb_fdma_wr_sched.sv - directed self-checking bench for fdma_wr_sched
module tb_fdma_wr_sched;

  logic         clk;
  logic         rst;
  logic [1:0]   ch_en;
  logic [1:0]   fs;
  logic [23:0]  rcnt;
  logic [15:0]  bufi;
  logic [255:0] dout;
  logic [1:0]   fifo_re;
  logic [1:0]   fifo_rst;
  logic [15:0]  sync_cnt;
  logic [15:0]  wbuf;
  logic [1:0]   wirq;
  logic [1:0]   ovf;

  fdma_wr_sched_if #(.AXI_DATA_WIDTH(128), .AXI_ADDR_WIDTH(32)) fdma ();

  fdma_wr_sched #(
    .CH_NUM(2), .AXI_DATA_WIDTH(128), .AXI_ADDR_WIDTH(32), .CNT_WIDTH(12),
    .W_DATAWIDTH(32), .W_BASEADDR(0), .W_DSIZEBITS(12), .CH_ADDR_SHIFT(20),
    .W_XSIZE(8), .W_XSTRIDE(16), .W_YSIZE(2), .W_XDIV(1), .W_BUFSIZE(3),
    .RST_CYCLES(4), .RST_GUARD(4), .IRQ_CYCLES(6), .VIDEO_ENABLE(1)
  ) dut (
    .I_ui_clk      (clk),
    .I_ui_rst      (rst),
    .I_ch_en       (ch_en),
    .I_W_FS        (fs),
    .I_W_rcnt      (rcnt),
    .I_W_buf       (bufi),
    .I_W_fifo_dout (dout),
    .O_fifo_re     (fifo_re),
    .O_fifo_rst    (fifo_rst),
    .O_W_sync_cnt  (sync_cnt),
    .fdma          (fdma),
    .O_fdma_wbuf   (wbuf),
    .O_fdma_wirq   (wirq),
    .O_fs_ovf      (ovf)
  );

  localparam logic [127:0] D0 = {4{32'hA0A0_0001}};
  localparam logic [127:0] D1 = {4{32'hB1B1_0002}};

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0]  addr_log [64];
  logic [127:0] data_log [64];
  int   addr_n  = 0;
  int   rst0_hi = 0;
  int   irq0_hi = 0;
  int   re0_n   = 0;
  int   re1_n   = 0;
  logic wreq_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FDMA master model: 3 busy cycles per request, data consumed on the first two.
  initial begin
    int cnt;
    cnt = 0;
    fdma.I_fdma_wbusy  = 1'b0;
    fdma.I_fdma_wvalid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cnt != 0) begin
        cnt--;
        fdma.I_fdma_wvalid = (cnt == 2);
        fdma.I_fdma_wbusy  = (cnt != 0);
      end else if (fdma.O_fdma_wareq) begin
        cnt = 3;
        fdma.I_fdma_wbusy  = 1'b1;
        fdma.I_fdma_wvalid = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    wreq_prev <= fdma.O_fdma_wareq;
    if (fdma.O_fdma_wareq && !wreq_prev && addr_n < 64) begin
      addr_log[addr_n] <= fdma.O_fdma_waddr;
      data_log[addr_n] <= fdma.O_fdma_wdata;
      addr_n <= addr_n + 1;
    end
    rst0_hi <= rst0_hi + int'(fifo_rst[0]);
    irq0_hi <= irq0_hi + int'(wirq[0]);
    re0_n   <= re0_n + int'(fifo_re[0]);
    re1_n   <= re1_n + int'(fifo_re[1]);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_fs(input int ch, input logic [7:0] b);
    @(negedge clk);
    bufi[ch*8 +: 8] = b;
    fs[ch] = 1'b1;
    @(negedge clk);
    fs[ch] = 1'b0;
  endtask

  task automatic wait_addr(input int target, input string nm);
    int t;
    t = 0;
    while (addr_n < target && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (addr_n < target) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: timeout, bursts got %0d want %0d", nm, addr_n, target);
    end
  endtask

  task automatic wait_frame_done(input int ch, input string nm);
    int t;
    t = 0;
    while (!wirq[ch] && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!wirq[ch]) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: irq never rose", nm);
    end
    t = 0;
    while (wirq[ch] && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (wirq[ch]) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: irq never fell", nm);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (fdma.O_fdma_wareq !== 1'b0) begin n_fail++; $display("FAIL rst_wareq: got %b want 0", fdma.O_fdma_wareq); end
    n_cmp++; if (fdma.O_fdma_waddr !== 32'h0) begin n_fail++; $display("FAIL rst_waddr: got %h want 0", fdma.O_fdma_waddr); end
    n_cmp++; if (fdma.O_fdma_wsize !== 16'h0) begin n_fail++; $display("FAIL rst_wsize: got %h want 0", fdma.O_fdma_wsize); end
    n_cmp++; if ({fifo_rst, wirq, ovf, fifo_re} !== 8'h0) begin n_fail++; $display("FAIL rst_flags: got %h want 0", {fifo_rst, wirq, ovf, fifo_re}); end
    n_cmp++; if ({sync_cnt, wbuf} !== 32'h0) begin n_fail++; $display("FAIL rst_cnts: got %h want 0", {sync_cnt, wbuf}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int s, r0, i0;
    ch_en = 2'b01;
    rcnt[11:0] = 12'd2;
    s = addr_n; r0 = rst0_hi; i0 = irq0_hi;
    pulse_fs(0, 8'd1);
    wait_addr(s + 2, "t1_bursts");
    wait_frame_done(0, "t1_frame");
    n_cmp++; if (rst0_hi - r0 !== 4) begin n_fail++; $display("FAIL t1_fifo_rst_len: got %0d want 4", rst0_hi - r0); end
    n_cmp++; if (addr_log[s] !== 32'h1000) begin n_fail++; $display("FAIL t1_addr0: got %h want 1000", addr_log[s]); end
    n_cmp++; if (addr_log[s+1] !== 32'h1040) begin n_fail++; $display("FAIL t1_addr1: got %h want 1040", addr_log[s+1]); end
    n_cmp++; if (irq0_hi - i0 !== 6) begin n_fail++; $display("FAIL t1_irq_len: got %0d want 6", irq0_hi - i0); end
    n_cmp++; if (wbuf[7:0] !== 8'd1) begin n_fail++; $display("FAIL t1_wbuf: got %0d want 1", wbuf[7:0]); end
    n_cmp++; if (sync_cnt[7:0] !== 8'd1) begin n_fail++; $display("FAIL t1_sync: got %0d want 1", sync_cnt[7:0]); end
    n_cmp++; if (fdma.O_fdma_wsize !== 16'd2) begin n_fail++; $display("FAIL t1_wsize: got %0d want 2", fdma.O_fdma_wsize); end
  endtask

  task automatic test_round_robin();
    int s, e0, e1;
    logic [31:0] exp_a [4];
    logic [127:0] exp_d [4];
    exp_a[0] = 32'h2000;   exp_d[0] = D0;
    exp_a[1] = 32'h100000; exp_d[1] = D1;
    exp_a[2] = 32'h2040;   exp_d[2] = D0;
    exp_a[3] = 32'h100040; exp_d[3] = D1;
    do_reset();
    ch_en = 2'b11;
    rcnt = {12'd2, 12'd2};
    s = addr_n; e0 = re0_n; e1 = re1_n;
    @(negedge clk);
    bufi = {8'd0, 8'd2};
    fs = 2'b11;
    @(negedge clk);
    fs = 2'b00;
    wait_addr(s + 4, "t2_bursts");
    wait_frame_done(1, "t2_frame");
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (addr_log[s+i] !== exp_a[i]) begin n_fail++; $display("FAIL t2_addr%0d: got %h want %h", i, addr_log[s+i], exp_a[i]); end
      n_cmp++; if (data_log[s+i] !== exp_d[i]) begin n_fail++; $display("FAIL t2_data%0d: got %h want %h", i, data_log[s+i], exp_d[i]); end
    end
    n_cmp++; if (re0_n - e0 !== 4) begin n_fail++; $display("FAIL t2_re0: got %0d want 4", re0_n - e0); end
    n_cmp++; if (re1_n - e1 !== 4) begin n_fail++; $display("FAIL t2_re1: got %0d want 4", re1_n - e1); end
    n_cmp++; if (wbuf !== 16'h0002) begin n_fail++; $display("FAIL t2_wbuf: got %h want 0002", wbuf); end
  endtask

  task automatic test_threshold();
    int s;
    logic seen;
    do_reset();
    ch_en = 2'b01;
    rcnt = {12'd0, 12'd1};
    s = addr_n;
    pulse_fs(0, 8'd0);
    repeat (20) @(negedge clk);
    n_cmp++; if (addr_n - s !== 0) begin n_fail++; $display("FAIL t3_no_req: got %0d bursts want 0", addr_n - s); end
    rcnt[11:0] = 12'd2;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (fdma.O_fdma_wareq) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL t3_req_latency: got %b want 1", seen); end
    wait_frame_done(0, "t3_frame");
  endtask

  task automatic test_fs_overflow();
    int s;
    do_reset();
    ch_en = 2'b01;
    rcnt = {12'd0, 12'd2};
    s = addr_n;
    pulse_fs(0, 8'd1);
    wait_addr(s + 1, "t4_first");
    pulse_fs(0, 8'd3);
    wait_addr(s + 2, "t4_second");
    wait_frame_done(0, "t4_frame");
    n_cmp++; if (ovf !== 2'b01) begin n_fail++; $display("FAIL t4_ovf: got %b want 01", ovf); end
    n_cmp++; if (addr_log[s+1] !== 32'h1040) begin n_fail++; $display("FAIL t4_addr1: got %h want 1040", addr_log[s+1]); end
    n_cmp++; if (wbuf[7:0] !== 8'd1) begin n_fail++; $display("FAIL t4_wbuf: got %0d want 1", wbuf[7:0]); end
    repeat (10) @(negedge clk);
    n_cmp++; if (addr_n - s !== 2) begin n_fail++; $display("FAIL t4_no_extra: got %0d bursts want 2", addr_n - s); end
  endtask

  task automatic test_reset_mid_burst();
    int s, t;
    s = addr_n;
    pulse_fs(0, 8'd1);
    t = 0;
    while (!(fdma.I_fdma_wbusy && !fdma.O_fdma_wareq) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL t5_busy: timeout waiting for busy");
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (fdma.O_fdma_wareq !== 1'b0) begin n_fail++; $display("FAIL t5_wareq: got %b want 0", fdma.O_fdma_wareq); end
    n_cmp++; if (fdma.O_fdma_waddr !== 32'h0) begin n_fail++; $display("FAIL t5_waddr: got %h want 0", fdma.O_fdma_waddr); end
    n_cmp++; if ({fifo_rst, wirq, ovf, fifo_re} !== 8'h0) begin n_fail++; $display("FAIL t5_flags: got %h want 0", {fifo_rst, wirq, ovf, fifo_re}); end
    n_cmp++; if (sync_cnt !== 16'h0) begin n_fail++; $display("FAIL t5_sync: got %h want 0", sync_cnt); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    s = addr_n;
    pulse_fs(0, 8'd1);
    wait_addr(s + 2, "t5_bursts");
    wait_frame_done(0, "t5_frame");
    n_cmp++; if (addr_log[s] !== 32'h1000) begin n_fail++; $display("FAIL t5_restart_addr: got %h want 1000", addr_log[s]); end
    n_cmp++; if (addr_log[s+1] !== 32'h1040) begin n_fail++; $display("FAIL t5_restart_addr1: got %h want 1040", addr_log[s+1]); end
  endtask

  task automatic test_buffer_rotation();
    logic [7:0] exp_sync [3];
    exp_sync[0] = 8'd1; exp_sync[1] = 8'd2; exp_sync[2] = 8'd0;
    do_reset();
    ch_en = 2'b01;
    rcnt = {12'd0, 12'd2};
    for (int f = 0; f < 3; f++) begin
      pulse_fs(0, 8'(f));
      n_cmp++; if (sync_cnt[7:0] !== exp_sync[f]) begin n_fail++; $display("FAIL t6_sync%0d: got %0d want %0d", f, sync_cnt[7:0], exp_sync[f]); end
      wait_frame_done(0, "t6_frame");
      n_cmp++; if (wbuf[7:0] !== 8'(f)) begin n_fail++; $display("FAIL t6_wbuf%0d: got %0d want %0d", f, wbuf[7:0], f); end
    end
  endtask

  task automatic test_disable_armed();
    int s;
    do_reset();
    ch_en = 2'b10;
    rcnt = {12'd0, 12'd0};
    s = addr_n;
    pulse_fs(1, 8'd0);
    repeat (15) @(negedge clk);
    ch_en = 2'b00;
    repeat (3) @(negedge clk);
    rcnt[23:12] = 12'd2;
    repeat (10) @(negedge clk);
    n_cmp++; if (addr_n - s !== 0) begin n_fail++; $display("FAIL t7_disabled: got %0d bursts want 0", addr_n - s); end
    ch_en = 2'b10;
    pulse_fs(1, 8'd0);
    wait_addr(s + 2, "t7_bursts");
    wait_frame_done(1, "t7_frame");
    n_cmp++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL t7_ovf: got %b want 00", ovf); end
    n_cmp++; if (addr_log[s] !== 32'h100000) begin n_fail++; $display("FAIL t7_addr0: got %h want 100000", addr_log[s]); end
  endtask

  initial begin
    rst   = 1'b1;
    ch_en = 2'b00;
    fs    = 2'b00;
    rcnt  = '0;
    bufi  = '0;
    dout  = {D1, D0};
    test_reset();
    test_single_frame();
    test_round_robin();
    test_threshold();
    test_fs_overflow();
    test_reset_mid_burst();
    test_buffer_rotation();
    test_disable_armed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
